// File: rtl/simple_ram_pkg.sv
// Shared types and sizing helpers for the simple_ram scratch memory.
// Imported by the clear sequencer and the top level.
package simple_ram_pkg;

   typedef enum logic {
      CLEAR,
      READY
   } ramState_t;

   // The depth is derived from the address width so that every address is valid.
   function automatic int ramDepth(input int addrWidth);
      return 1 << addrWidth;
   endfunction

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_ADDR_WIDTH = 8;
   localparam int DEPTH              = ramDepth(DEFAULT_ADDR_WIDTH);

endpackage

// File: rtl/simple_ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, asking the RAM to
// write zero there, then raises ready and stays idle until the next reset.
module ram_clear_seq
   import simple_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output logic                  ready
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ramDepth(ADDR_WIDTH) - 1);

   ramState_t             r_state;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic                  r_ready;

   // One zeroing write per clock; ready rises on the edge that clears the last word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= CLEAR;
         r_ptr   <= '0;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_ptr <= r_ptr + 1'b1;
               if (r_ptr == LAST_ADDR) begin
                  r_state <= READY;
                  r_ready <= 1'b1;
               end
            end
            READY: begin
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= CLEAR;
               r_ptr   <= '0;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign clr_we   = (r_state == CLEAR);
   assign clr_addr = r_ptr;
   assign ready    = r_ready;

endmodule

// File: rtl/simple_ram.sv
// Single-port RAM: synchronous write, combinational read on a shared address.
// Contents are zeroed by ram_clear_seq after every reset before users get access.
module simple_ram
   import simple_ram_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  ready
);

   localparam int MEM_DEPTH = ramDepth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

   logic                  w_clrWe;
   logic [ADDR_WIDTH-1:0] w_clrAddr;
   logic                  w_ready;
   logic                  w_memWe;
   logic [ADDR_WIDTH-1:0] w_memAddr;
   logic [DATA_WIDTH-1:0] w_memData;

   ram_clear_seq #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clearSeq (
      .clk      (clk),
      .rst      (rst),
      .clr_we   (w_clrWe),
      .clr_addr (w_clrAddr),
      .ready    (w_ready)
   );

   // The clear sequencer owns the write port until it is done; user writes only count once ready.
   assign w_memWe   = w_clrWe | (w_ready & we);
   assign w_memAddr = w_clrWe ? w_clrAddr : addr;
   assign w_memData = w_clrWe ? '0 : data_in;

   always_ff @(posedge clk) begin
      if (w_memWe) begin
         r_mem[w_memAddr] <= w_memData;
      end
   end

   assign data_out = w_ready ? r_mem[addr] : '0;
   assign ready    = w_ready;

endmodule

// File: tb/tb_simple_ram.sv
// Self-checking bench for simple_ram: directed scenarios plus randomized
// traffic compared against a plain array model of the memory.
module tb_simple_ram;

   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   logic          clk;
   logic          rst;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          ready;

   logic [DW-1:0] model [DEPTH];
   int            assertCount;
   int            failCount;

   simple_ram #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .addr     (addr),
      .data_in  (data_in),
      .data_out (data_out),
      .ready    (ready)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drives all user inputs just after a falling edge, well away from the active edge.
   task automatic applyStimulus(input logic weV, input logic [AW-1:0] addrV, input logic [DW-1:0] dataV);
      @(negedge clk);
      we      = weV;
      addr    = addrV;
      data_in = dataV;
   endtask

   // A user write as seen by the model: the word lands on the next rising edge.
   task automatic writeWord(input logic [AW-1:0] a, input logic [DW-1:0] d);
      applyStimulus(1'b1, a, d);
      @(posedge clk);
      model[a] = d;
      #1;
      checkOutput("writeVisible", data_out, d);
   endtask

   // Runs a whole clear after rst has been released, hammering writes to 0x05 throughout.
   task automatic runClear();
      we      = 1'b1;
      addr    = 8'h05;
      data_in = 8'hFF;
      for (int i = 1; i <= DEPTH; i++) begin
         @(posedge clk);
         #1;
         checkOutput("clearReady", {31'd0, ready}, {31'd0, (i == DEPTH)});
         checkOutput("clearDataOut", data_out, 32'h0);
      end
      we = 1'b0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      we          = 1'b0;
      addr        = '0;
      data_in     = '0;
      rst         = 1'b1;

      // Reset acts without any clock edge.
      #1;
      checkOutput("resetReady", {31'd0, ready}, 32'h0);
      checkOutput("resetDataOut", data_out, 32'h0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      runClear();

      // Freshly cleared locations, including the write attempted during clear.
      addr = 8'h00; #1 checkOutput("cleared00", data_out, 32'h0);
      addr = 8'h7F; #1 checkOutput("cleared7F", data_out, 32'h0);
      addr = 8'hFF; #1 checkOutput("clearedFF", data_out, 32'h0);
      addr = 8'h05; #1 checkOutput("clearIgnoredWe", data_out, 32'h0);

      // Write then hold the read address.
      writeWord(8'h10, 8'hA5);
      applyStimulus(1'b0, 8'h10, 8'h00);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checkOutput("holdRead10", data_out, 32'hA5);
      end

      // Combinational read follows addr between edges.
      writeWord(8'h01, 8'h11);
      writeWord(8'h02, 8'h22);
      applyStimulus(1'b0, 8'h01, 8'h00);
      #1 checkOutput("combRead01", data_out, 32'h11);
      addr = 8'h02;
      #1 checkOutput("combRead02", data_out, 32'h22);
      addr = 8'h01;
      #1 checkOutput("combRead01b", data_out, 32'h11);

      // Read during write to the same address: old word before the edge, new after.
      writeWord(8'h30, 8'h5A);
      applyStimulus(1'b1, 8'h30, 8'hC3);
      #1 checkOutput("rdwBefore", data_out, 32'h5A);
      @(posedge clk);
      model[8'h30] = 8'hC3;
      #1 checkOutput("rdwAfter", data_out, 32'hC3);

      // Randomized traffic against the array model.
      for (int i = 0; i < 2000; i++) begin
         logic          rWe;
         logic [AW-1:0] rAddr;
         logic [DW-1:0] rData;
         rWe   = 1'($urandom_range(0, 1));
         rAddr = (i % 2 == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
         rData = DW'($urandom);
         applyStimulus(rWe, rAddr, rData);
         #1 checkOutput("randRead", data_out, {24'd0, model[rAddr]});
         checkOutput("randReady", {31'd0, ready}, 32'h1);
         @(posedge clk);
         if (rWe) model[rAddr] = rData;
         #1 checkOutput("randPost", data_out, {24'd0, model[rAddr]});
      end

      // Fill low addresses, then reset asynchronously mid-cycle.
      for (int i = 0; i < 16; i++) writeWord(AW'(i), DW'(8'h40 + i));
      applyStimulus(1'b0, 8'h03, 8'h00);
      #1 checkOutput("preResetRead", data_out, 32'h43);
      #1 rst = 1'b1;
      #1;
      checkOutput("midResetReady", {31'd0, ready}, 32'h0);
      checkOutput("midResetDataOut", data_out, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      runClear();
      for (int i = 0; i < DEPTH; i++) begin
         addr = AW'(i);
         #1 checkOutput("postResetSweep", data_out, {24'd0, model[i]});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
